branch_predictor: RTL
=====================

# branch_predictor

Parametrised branch target buffer with 2-bit saturating direction counters for the pipelined RV32 core. It sits beside the PC register in IF and supplies a predicted next PC every cycle. It is trained non-speculatively from branch/jump resolution in EX. It replaces the fixed `pc + 4` next-PC path and optionally hashes a global history register into the index (gshare).

## Interface
- `ENTRIES`, 32: number of BTB entries; power of two, ≥ 2; `IDX_BITS = $clog2(ENTRIES)`
- `PC_WIDTH`, 32: PC and target width; ≥ `IDX_BITS + 3`
- `GHR_BITS`, 5: global history length; ≤ `IDX_BITS`; used only with gshare
- `clk` input 1: clock; all state updates on rising edge
- `reset` input 1: asynchronous, active-low (0 = reset)
- `pred_pc` input PC_WIDTH: current fetch PC
- `pred_hit` output 1: valid entry with matching tag at the lookup index
- `pred_taken` output 1: `pred_hit && counter[1]`
- `pred_target` output PC_WIDTH: stored target if `pred_taken`, else `pred_pc + 4`
- `pred_idx` output IDX_BITS: index used for this lookup; piped to EX and returned as `upd_idx`
- `upd_valid` input 1: a control-flow instruction resolved in EX this cycle
- `upd_pc` input PC_WIDTH: PC of the resolved instruction
- `upd_idx` input IDX_BITS: `pred_idx` captured when that instruction was fetched
- `upd_taken` input 1: actual direction
- `upd_target` input PC_WIDTH: actual target address

## Operation
- Per entry: `valid` (1b), `tag` (`PC_WIDTH-IDX_BITS-2` bits = `pc[PC_WIDTH-1:IDX_BITS+2]`), `target` (PC_WIDTH), `ctr` (2b).
- Lookup index: `pred_pc[IDX_BITS+1:2]`. With gshare, XOR its low GHR_BITS with the GHR.
- Lookup is purely combinational from the stored state. `pred_pc[1:0]` is ignored. `pred_pc + 4` wraps modulo 2^PC_WIDTH.
- Update on `upd_valid` writes entry `upd_idx`:
  - Hit (valid, and tag equals upd_pc's tag): `ctr` saturating +1 if taken, −1 if not. The range is 00..11 and it never wraps. `target` is rewritten only when taken.
  - Miss: allocate unconditionally (replacement). Set `valid=1`, `tag` from upd_pc, `target=upd_target`, `ctr = upd_taken ? 2'b10 : 2'b01`.
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- GHR (gshare only): on `upd_valid`, `ghr <= {ghr[GHR_BITS-2:0], upd_taken}`. It is not updated speculatively and has no repair logic.
- Reset state, asserted asynchronously:
  - All `valid=0`, all `ctr=2'b01`, `ghr=0`. `tag` and `target` are don't-care.
  - Outputs during and after reset until trained: `pred_hit=0`, `pred_taken=0`, `pred_target=pred_pc+4`, `pred_idx=pred_pc[IDX_BITS+1:2]`.

## Timing
- Lookup latency is 0 cycles: outputs follow `pred_pc` combinationally within the same cycle.
- An update is visible to lookups from the cycle after the `upd_valid` edge.
- Lookup and update to the same index in the same cycle: the lookup returns the pre-update contents. There is no write-through bypass.
- Only one update per cycle. `upd_*` are ignored when `upd_valid=0`.
- Reset asserted mid-cycle clears state immediately, without waiting for a clock edge. An update coincident with reset is discarded. The first update takes effect on the first rising edge with `reset=1`.
- Stall and flush are handled outside the block. The core must drive `upd_valid=0` for squashed instructions.

## Configuration
- `BRANCH_PREDICTOR_GSHARE_EN` defined: the GHR register exists and the lookup index is `pred_pc[IDX_BITS+1:2] ^ {{(IDX_BITS-GHR_BITS){1'b0}}, ghr}`.
- Not defined: no GHR flops are instantiated, the index is `pred_pc[IDX_BITS+1:2]` (bimodal), and `GHR_BITS` is unused.

## Test plan
All scenarios use defaults, no gshare unless noted.
- **Reset lookup:** after reset, `pred_pc=0x100` → `pred_hit=0`, `pred_taken=0`, `pred_target=0x104`, `pred_idx=0`.
- **Allocate and hit:** update `upd_pc=0x100`, idx 0, taken, target `0x40`. Next cycle `pred_pc=0x100` → hit=1, taken=1, target=`0x40`. In the update cycle itself, a lookup of `0x100` → hit=0.
- **Counter saturation:**
  - From ctr=10, three not-taken updates → ctr 01, 00, 00; `pred_taken=0`, target=`0x104`.
  - Then two taken updates → 01, 10; `pred_taken=1`.
  - Four more taken → ctr stays 11.
- **Alias replacement:** `pred_pc=0x180` (idx 0, different tag) → hit=0. Update 0x180 not-taken → `0x180` hits with taken=0, and `0x100` now misses.
- **Asynchronous reset mid-operation:** with the `0x100` entry trained, drive `reset=0` between edges → `pred_hit` drops to 0 before the next edge. After release, every entry misses.
- **Gshare (`BRANCH_PREDICTOR_GSHARE_EN`):** updates taken, taken, not-taken → ghr=`5'b00110`. `pred_pc=0x100` → `pred_idx=6`. `pred_pc=0x118` → `pred_idx=0`.

Source files
------------

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped branch target buffer with 2-bit saturating
// direction counters. Lookup is combinational from pred_pc; training comes from
// EX resolution. Define BRANCH_PREDICTOR_GSHARE_EN to XOR a global history
// register into the lookup index (gshare); otherwise the index is bimodal.
module branch_predictor #(
    parameter int unsigned ENTRIES  = 32,
    parameter int unsigned PC_WIDTH = 32,
    parameter int unsigned GHR_BITS = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [PC_WIDTH-1:0]         pred_pc,
    output logic                        pred_hit,
    output logic                        pred_taken,
    output logic [PC_WIDTH-1:0]         pred_target,
    output logic [$clog2(ENTRIES)-1:0]  pred_idx,
    input  logic                        upd_valid,
    input  logic [PC_WIDTH-1:0]         upd_pc,
    input  logic [$clog2(ENTRIES)-1:0]  upd_idx,
    input  logic                        upd_taken,
    input  logic [PC_WIDTH-1:0]         upd_target
);

    localparam int unsigned IDX_BITS = $clog2(ENTRIES);
    localparam int unsigned TAG_LSB  = IDX_BITS + 2;
    localparam int unsigned TAG_BITS = PC_WIDTH - TAG_LSB;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // Reject parameter sets the indexing scheme cannot support
    if (ENTRIES < 2 || (1 << IDX_BITS) != ENTRIES || PC_WIDTH < IDX_BITS + 3
        || GHR_BITS > IDX_BITS) begin : g_bad_params
        $error("branch_predictor: illegal parameter combination");
    end

    logic                valid_q  [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [PC_WIDTH-1:0] target_q [ENTRIES];

    logic [IDX_BITS-1:0] base_idx;
    logic [IDX_BITS-1:0] lkp_idx;
    logic [TAG_BITS-1:0] upd_tag;
    logic                upd_hit;
    logic [1:0]          ctr_cur;
    logic [1:0]          ctr_nxt;
    logic                wr_target;

    assign base_idx = pred_pc[TAG_LSB-1:2];

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    logic [GHR_BITS-1:0] ghr_q;

    assign lkp_idx = base_idx ^ IDX_BITS'(ghr_q);

    // Global history: shift in each resolved direction, non-speculatively
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ghr_q <= '0;
        end else if (upd_valid) begin
            ghr_q <= GHR_BITS'({ghr_q, upd_taken});
        end
    end
`else
    assign lkp_idx = base_idx;
`endif

    // Lookup: pure function of stored state and pred_pc, no bypass from update
    always_comb begin
        pred_idx    = lkp_idx;
        pred_hit    = valid_q[lkp_idx] && (tag_q[lkp_idx] == pred_pc[PC_WIDTH-1:TAG_LSB]);
        pred_taken  = pred_hit && ctr_q[lkp_idx][1];
        pred_target = pred_taken ? target_q[lkp_idx] : pred_pc + PC_WIDTH'(4);
    end

    // Training decision: saturating counter step on hit, fresh weak state on miss
    always_comb begin
        upd_tag   = upd_pc[PC_WIDTH-1:TAG_LSB];
        upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        ctr_cur   = ctr_q[upd_idx];
        ctr_nxt   = upd_taken ? CTR_WT : CTR_WNT;
        wr_target = upd_taken || !upd_hit;
        if (upd_hit) begin
            ctr_nxt = ctr_cur;
            if (upd_taken && ctr_cur != CTR_ST) begin
                ctr_nxt = ctr_cur + 2'd1;
            end else if (!upd_taken && ctr_cur != CTR_SNT) begin
                ctr_nxt = ctr_cur - 2'd1;
            end
        end
    end

    // Valid bits and counters: cleared asynchronously, trained on upd_valid
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_WNT;
            end
        end else if (upd_valid) begin
            valid_q[upd_idx] <= 1'b1;
            ctr_q[upd_idx]   <= ctr_nxt;
        end
    end

    // Tag/target payload; a write coincident with reset lands in an invalid entry
    always_ff @(posedge clk) begin
        if (upd_valid) begin
            tag_q[upd_idx] <= upd_tag;
            if (wr_target) begin
                target_q[upd_idx] <= upd_target;
            end
        end
    end

    // Byte offset bits and the update PC's index field are not needed here
    logic unused_bits;
    assign unused_bits = ^{pred_pc[1:0], upd_pc[TAG_LSB-1:0]};

endmodule
